midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
//  Polyphonic voice scheduler between MIDI packet parsing and per-voice oscillator/ADSR.
//  Accepts note-on/off events and assigns each one to one of NUM_VOICES voices:
//  - retrigger a voice already holding the same note;
//  - otherwise take a free voice;
//  - otherwise steal the oldest voice.
//  Emits one single-cycle update per event carrying voice index, note, velocity and gate.
// PARAMETERS
//  NUM_VOICES  4   voices managed; power of two, >=2
//  VOICE_BITS  2   log2(NUM_VOICES)
//  BYTE_W      8   velocity width
//  NOTE_W      7   MIDI note number width
// PORTS
//  sys_clk         in   1           system clock, all logic posedge
//  rst_n           in   1           asynchronous active-low reset
//  ev_valid        in   1           event present
//  ev_ready        out  1           =1 only in IDLE; event accepted when valid&ready
//  ev_note_on      in   1           1=note-on, 0=note-off
//  ev_note         in   NOTE_W      note number
//  ev_velocity     in   BYTE_W      velocity; note-on with 0 is treated as note-off
//  voice_sel       out  VOICE_BITS  voice being updated
//  voice_note      out  NOTE_W      note assigned to voice_sel
//  voice_velocity  out  BYTE_W      velocity for voice_sel (0 on release)
//  voice_gate      out  1           1=key down, 0=release
//  voice_update    out  1           1-cycle strobe; other voice_* outputs valid with it
//  voice_active    out  NUM_VOICES  gate bit per voice, registered
// BEHAVIOUR
//  Reset: state=IDLE; voice_sel, voice_note, voice_velocity, voice_gate, voice_update and voice_active all 0.
//   Per-voice note table=0; age rank[i]=i (voice NUM_VOICES-1 oldest). In-flight event dropped, no strobe.
//  FSM: IDLE -> SCAN -> ISSUE -> IDLE.
//   IDLE : ev_ready=1. On accept, latch on/note/vel; vel==0 forces on=0.
//   SCAN : one cycle, compute target from latched event and table.
//   ISSUE: write table, drive outputs, voice_update=1 this cycle only.
//  Latency: accept at cycle N -> voice_update at N+2; next accept earliest N+3.
//  Note-on target priority:
//   (1) lowest-index voice with gate=1 and same note (retrigger);
//   (2) lowest-index voice with gate=0;
//   (3) voice with rank==NUM_VOICES-1 (steal).
//   Set gate=1, note, vel; voice_gate=1.
//  Age update on every note-on: target rank r->0; voices with rank<r increment; others hold.
//   Ranks always remain a permutation of 0..NUM_VOICES-1.
//  Note-off: target = lowest-index voice with gate=1 and matching note.
//   Match: gate=0, voice_velocity=0, voice_note=stored note, strobe; ranks unchanged.
//   No match: no strobe, table unchanged; still returns to IDLE via ISSUE.
//  Duplicate notes cannot exist, because of rule (1).
//  voice_sel/note/velocity/gate hold their last value between strobes.
//  voice_active updates in the ISSUE cycle and is visible the cycle after the strobe.
//  ev_* ignored outside IDLE; upstream holds ev_valid until accepted.
//  rst_n assertion at any state -> immediate reset values; no partial table write.
// TESTING
//  1 Reset, on(60,100) -> N+2: sel=0 note=60 vel=100 gate=1 strobe 1 cycle; active=0001.
//  2 on 60,62,64,67 -> sel 0,1,2,3; active=1111; then on 72 -> steal sel=0 (oldest), active=1111.
//  3 After 2: on 64 vel 50 -> retrigger sel=2 vel=50; next steal targets voice 1.
//  4 on(60) then off(61) -> no second strobe, active unchanged; off(60) -> sel=0 gate=0 vel=0.
//  5 on(60, vel=0) with voice 0 holding 60 -> release of sel=0; ev_valid held 3 cycles -> one accept.
//  6 rst_n low during SCAN -> no strobe, outputs 0, ranks restored to 0..3.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES voices
// (retrigger same note, else free voice, else steal oldest) and strobes one update per event.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VOICE_BITS = 2,
    parameter int BYTE_W     = 8,
    parameter int NOTE_W     = 7
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_note_on,
    input  logic [NOTE_W-1:0]     ev_note,
    input  logic [BYTE_W-1:0]     ev_velocity,
    output logic [VOICE_BITS-1:0] voice_sel,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [BYTE_W-1:0]     voice_velocity,
    output logic                  voice_gate,
    output logic                  voice_update,
    output logic [NUM_VOICES-1:0] voice_active
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE} state_t;

    state_t state, state_nxt;

    logic                  on_q;
    logic [NOTE_W-1:0]     note_q;
    logic [BYTE_W-1:0]     vel_q;
    logic [NOTE_W-1:0]     note_tab [NUM_VOICES];
    logic [VOICE_BITS-1:0] rank_tab [NUM_VOICES];
    logic                  hit_q;
    logic [VOICE_BITS-1:0] tgt_q;

    logic                  retrig_found, free_found, tgt_hit;
    logic [VOICE_BITS-1:0] retrig_idx, free_idx, old_idx, tgt_idx;

    // voice_active doubles as the per-voice gate table
    always_comb begin
        retrig_found = 1'b0;
        retrig_idx   = '0;
        free_found   = 1'b0;
        free_idx     = '0;
        old_idx      = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!retrig_found && voice_active[i] && note_tab[i] == note_q) begin
                retrig_found = 1'b1;
                retrig_idx   = VOICE_BITS'(i);
            end
            if (!free_found && !voice_active[i]) begin
                free_found = 1'b1;
                free_idx   = VOICE_BITS'(i);
            end
            if (rank_tab[i] == VOICE_BITS'(NUM_VOICES - 1))
                old_idx = VOICE_BITS'(i);
        end
        if (on_q) begin
            tgt_hit = 1'b1;
            tgt_idx = retrig_found ? retrig_idx : (free_found ? free_idx : old_idx);
        end else begin
            tgt_hit = retrig_found;
            tgt_idx = retrig_idx;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ev_ready     = 1'b0;
        voice_update = 1'b0;
        case (state)
            ST_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) state_nxt = ST_SCAN;
            end
            ST_SCAN:  state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                voice_update = hit_q;
                state_nxt    = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q           <= 1'b0;
            note_q         <= '0;
            vel_q          <= '0;
            hit_q          <= 1'b0;
            tgt_q          <= '0;
            voice_sel      <= '0;
            voice_note     <= '0;
            voice_velocity <= '0;
            voice_gate     <= 1'b0;
            voice_active   <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                note_tab[i] <= '0;
                rank_tab[i] <= VOICE_BITS'(i);
            end
        end else begin
            if (ev_ready && ev_valid) begin
                on_q   <= ev_note_on && (ev_velocity != '0);
                note_q <= ev_note;
                vel_q  <= ev_velocity;
            end
            // Outputs are registered at the end of SCAN so they appear with the ISSUE strobe
            if (state == ST_SCAN) begin
                hit_q <= tgt_hit;
                tgt_q <= tgt_idx;
                if (tgt_hit) begin
                    voice_sel      <= tgt_idx;
                    voice_note     <= on_q ? note_q : note_tab[tgt_idx];
                    voice_velocity <= on_q ? vel_q : '0;
                    voice_gate     <= on_q;
                end
            end
            if (state == ST_ISSUE && hit_q) begin
                voice_active[tgt_q] <= on_q;
                if (on_q) begin
                    note_tab[tgt_q] <= note_q;
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (VOICE_BITS'(i) == tgt_q)
                            rank_tab[i] <= '0;
                        else if (rank_tab[i] < rank_tab[tgt_q])
                            rank_tab[i] <= rank_tab[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized self-checking bench for midi_voice_allocator against a list-based voice model.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_note_on = 1'b0;
    logic [6:0] ev_note = '0;
    logic [7:0] ev_velocity = '0;
    logic [1:0] voice_sel;
    logic [6:0] voice_note;
    logic [7:0] voice_velocity;
    logic       voice_gate;
    logic       voice_update;
    logic [3:0] voice_active;

    midi_voice_allocator #(
        .NUM_VOICES(4), .VOICE_BITS(2), .BYTE_W(8), .NOTE_W(7)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_note_on(ev_note_on),
        .ev_note(ev_note), .ev_velocity(ev_velocity),
        .voice_sel(voice_sel), .voice_note(voice_note), .voice_velocity(voice_velocity),
        .voice_gate(voice_gate), .voice_update(voice_update), .voice_active(voice_active)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: gate/note per voice, plus a recency list (front = most recently started)
    bit m_gate [NV];
    int m_note [NV];
    int m_age [$];
    int o_sel, o_note, o_vel;
    bit o_gate;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
        end
        m_age = {0, 1, 2, 3};
        o_sel = 0; o_note = 0; o_vel = 0; o_gate = 0;
    endtask

    function automatic logic [3:0] m_active();
        logic [3:0] a;
        for (int i = 0; i < NV; i++) a[i] = m_gate[i];
        return a;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_sel"},  32'(voice_sel), 32'(o_sel));
        check({tag, "_note"}, 32'(voice_note), 32'(o_note));
        check({tag, "_vel"},  32'(voice_velocity), 32'(o_vel));
        check({tag, "_gate"}, 32'(voice_gate), 32'(o_gate));
    endtask

    task automatic run_event(input bit on, input int note, input int vel, input bit hold);
        bit eff_on;
        int tgt;
        int n;
        eff_on = on && (vel != 0);
        tgt = -1;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_gate[i] && m_note[i] == note) tgt = i;
        if (eff_on && tgt < 0)
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_gate[i]) tgt = i;
        if (eff_on && tgt < 0) tgt = m_age[m_age.size() - 1];
        if (tgt >= 0) begin
            o_sel = tgt;
            if (eff_on) begin
                m_gate[tgt] = 1; m_note[tgt] = note;
                o_note = note; o_vel = vel; o_gate = 1;
                for (int k = 0; k < m_age.size(); k++)
                    if (m_age[k] == tgt) begin
                        m_age.delete(k);
                        break;
                    end
                m_age.push_front(tgt);
            end else begin
                m_gate[tgt] = 0;
                o_note = m_note[tgt]; o_vel = 0; o_gate = 0;
            end
        end

        @(negedge sys_clk);
        n = 0;
        while (!ev_ready && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check("ready_idle", 32'(ev_ready), 32'd1);
        ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(note); ev_velocity = 8'(vel);
        @(posedge sys_clk); #1;
        if (!hold) ev_valid = 1'b0;
        check("n1_update", 32'(voice_update), 32'd0);
        check("n1_ready", 32'(ev_ready), 32'd0);
        @(posedge sys_clk); #1;
        check("n2_update", 32'(voice_update), 32'(tgt >= 0));
        check_outputs("n2");
        @(posedge sys_clk); #1;
        ev_valid = 1'b0;
        check("n3_update", 32'(voice_update), 32'd0);
        check("n3_active", 32'(voice_active), 32'(m_active()));
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_update", 32'(voice_update), 32'd0);
        check("rst_active", 32'(voice_active), 32'd0);
        check_outputs("rst");
        @(negedge sys_clk);
        rst_n = 1'b1;

        // Basic allocation, fill, steal
        run_event(1, 60, 100, 0);
        run_event(1, 62, 90, 0);
        run_event(1, 64, 80, 0);
        run_event(1, 67, 70, 0);
        run_event(1, 72, 60, 0);
        check("steal_sel0", 32'(voice_sel), 32'd0);
        // Retrigger, then steal moves on to voice 1
        run_event(1, 64, 50, 0);
        check("retrig_sel2", 32'(voice_sel), 32'd2);
        run_event(1, 74, 40, 0);
        check("steal_sel1", 32'(voice_sel), 32'd1);
        // Unmatched and matched note-off, velocity-0 release with held valid
        run_event(0, 61, 0, 0);
        run_event(0, 72, 0, 0);
        run_event(1, 67, 0, 1);

        // Reset while an event is in SCAN
        @(negedge sys_clk);
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd50; ev_velocity = 8'd33;
        @(posedge sys_clk); #1;
        ev_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("scanrst_update", 32'(voice_update), 32'd0);
        check("scanrst_active", 32'(voice_active), 32'd0);
        check_outputs("scanrst");
        repeat (3) begin
            @(posedge sys_clk); #1;
            check("scanrst_nostrobe", 32'(voice_update), 32'd0);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        // Ranks restored: fill then steal must follow the fresh age order
        for (int i = 0; i < 5; i++) run_event(1, 40 + i, 10 + i, 0);

        for (int r = 0; r < 300; r++) begin
            bit on;
            int note, vel;
            on   = ($urandom_range(0, 9) < 6);
            note = 60 + $urandom_range(0, 6);
            vel  = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 127);
            run_event(on, note, vel, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
